// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one synchronous single-port memory between the CPU and DMA.
// One access per three cycles: IDLE (arbitrate) -> ISSUE (mem_en) -> WAIT (capture).
module mem_port_arbiter #(
  parameter int AW    = 12,
  parameter int DW    = 16,
  parameter bit RR_EN = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_done,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_done,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic          owner, owner_n;
  logic          last_gnt, last_gnt_n;
  logic          lat_we, lat_we_n;
  logic          win;
  logic          mem_en_n, mem_we_n;
  logic [AW-1:0] mem_addr_n;
  logic [DW-1:0] mem_wdata_n;
  logic          p0_gnt_n, p1_gnt_n;
  logic          p0_done_n, p1_done_n;
  logic [DW-1:0] p0_rdata_n, p1_rdata_n;
  logic          busy_n;

  // Port 1 wins when alone, or on a tie when round-robin says port 0 went last.
  always_comb begin
    win = 1'b1;
    if (p0_req)
      win = p1_req && RR_EN && !last_gnt;
  end

  always_comb begin
    state_n     = state;
    owner_n     = owner;
    last_gnt_n  = last_gnt;
    lat_we_n    = lat_we;
    mem_en_n    = 1'b0;
    mem_we_n    = 1'b0;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    p0_gnt_n    = 1'b0;
    p1_gnt_n    = 1'b0;
    p0_done_n   = 1'b0;
    p1_done_n   = 1'b0;
    p0_rdata_n  = p0_rdata;
    p1_rdata_n  = p1_rdata;
    unique case (state)
      IDLE: begin
        if (p0_req || p1_req) begin
          state_n     = ISSUE;
          owner_n     = win;
          lat_we_n    = win ? p1_we : p0_we;
          mem_en_n    = 1'b1;
          mem_we_n    = win ? p1_we : p0_we;
          mem_addr_n  = win ? p1_addr : p0_addr;
          mem_wdata_n = win ? p1_wdata : p0_wdata;
          p0_gnt_n    = !win;
          p1_gnt_n    = win;
        end
      end
      ISSUE: begin
        state_n    = WAIT;
        last_gnt_n = owner;
      end
      WAIT: begin
        state_n   = IDLE;
        p0_done_n = !owner;
        p1_done_n = owner;
        if (!lat_we) begin
          if (owner)
            p1_rdata_n = mem_rdata;
          else
            p0_rdata_n = mem_rdata;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last_gnt  <= 1'b1;
      lat_we    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      p0_gnt    <= 1'b0;
      p1_gnt    <= 1'b0;
      p0_done   <= 1'b0;
      p1_done   <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      last_gnt  <= last_gnt_n;
      lat_we    <= lat_we_n;
      mem_en    <= mem_en_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      p0_gnt    <= p0_gnt_n;
      p1_gnt    <= p1_gnt_n;
      p0_done   <= p0_done_n;
      p1_done   <= p1_done_n;
      p0_rdata  <= p0_rdata_n;
      p1_rdata  <= p1_rdata_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random two-requester traffic on a round-robin and a fixed-priority arbiter,
// each checked cycle by cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int AW   = 12;
  localparam int DW   = 16;
  localparam int NCYC = 5000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          req   [2][2];
  logic          we    [2][2];
  logic [AW-1:0] addr  [2][2];
  logic [DW-1:0] wdata [2][2];
  logic          gnt   [2][2];
  logic          done  [2][2];
  logic [DW-1:0] rdata [2][2];
  logic          m_en    [2];
  logic          m_we    [2];
  logic [AW-1:0] m_addr  [2];
  logic [DW-1:0] m_wdata [2];
  logic          busy    [2];

  function automatic logic [DW-1:0] seed(input int d, input logic [AW-1:0] a);
    logic [DW-1:0] x;
    x = {4'h0, a} * 16'd40503;
    return x ^ (d != 0 ? 16'h1357 : 16'h0000) ^ 16'hBEEF;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [DW-1:0] mem [4096];
    bit            wr  [4096];
    logic [DW-1:0] rd = '0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .RR_EN(g == 0)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .p0_req    (req[g][0]),
      .p0_we     (we[g][0]),
      .p0_addr   (addr[g][0]),
      .p0_wdata  (wdata[g][0]),
      .p0_gnt    (gnt[g][0]),
      .p0_done   (done[g][0]),
      .p0_rdata  (rdata[g][0]),
      .p1_req    (req[g][1]),
      .p1_we     (we[g][1]),
      .p1_addr   (addr[g][1]),
      .p1_wdata  (wdata[g][1]),
      .p1_gnt    (gnt[g][1]),
      .p1_done   (done[g][1]),
      .p1_rdata  (rdata[g][1]),
      .mem_en    (m_en[g]),
      .mem_we    (m_we[g]),
      .mem_addr  (m_addr[g]),
      .mem_wdata (m_wdata[g]),
      .mem_rdata (rd),
      .busy      (busy[g])
    );

    always @(posedge clk) begin
      if (m_en[g]) begin
        if (m_we[g]) begin
          mem[m_addr[g]] <= m_wdata[g];
          wr[m_addr[g]]  <= 1'b1;
        end else begin
          rd <= wr[m_addr[g]] ? mem[m_addr[g]] : seed(g, m_addr[g]);
        end
      end
    end
  end

  // Model: a slot is "age" cycles past its grant; expectations for the next edge.
  logic [DW-1:0] ref_mem [2][4096];
  int            age     [2];
  bit            own     [2];
  bit            last    [2];
  bit            l_we    [2];
  bit            e_gnt   [2][2];
  bit            e_done  [2][2];
  logic [DW-1:0] e_rdata [2][2];
  bit            e_en    [2];
  bit            e_we    [2];
  logic [AW-1:0] e_addr  [2];
  logic [DW-1:0] e_wdata [2];
  bit            e_busy  [2];
  bit            pend    [2][2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int d);
    int w;
    if (reset) begin
      if (age[d] == 1 && l_we[d])
        ref_mem[d][e_addr[d]] = e_wdata[d];
      age[d] = 0; own[d] = 0; last[d] = 1; l_we[d] = 0;
      e_en[d] = 0; e_we[d] = 0; e_addr[d] = '0; e_wdata[d] = '0; e_busy[d] = 0;
      for (int p = 0; p < 2; p++) begin
        e_gnt[d][p] = 0; e_done[d][p] = 0; e_rdata[d][p] = '0;
      end
      return;
    end
    for (int p = 0; p < 2; p++) begin
      e_gnt[d][p] = 0; e_done[d][p] = 0;
    end
    e_en[d] = 0; e_we[d] = 0;
    if (age[d] == 0) begin
      if (req[d][0] || req[d][1]) begin
        if (!req[d][0]) w = 1;
        else if (!req[d][1] || d != 0) w = 0;
        else w = last[d] ? 0 : 1;
        own[d] = w[0];
        l_we[d] = we[d][w];
        e_gnt[d][w] = 1;
        e_en[d] = 1;
        e_we[d] = we[d][w];
        e_addr[d] = addr[d][w];
        e_wdata[d] = wdata[d][w];
        age[d] = 1;
      end
    end else if (age[d] == 1) begin
      if (l_we[d]) ref_mem[d][e_addr[d]] = e_wdata[d];
      last[d] = own[d];
      age[d] = 2;
    end else begin
      e_done[d][own[d]] = 1;
      if (!l_we[d]) e_rdata[d][own[d]] = ref_mem[d][e_addr[d]];
      age[d] = 0;
    end
    e_busy[d] = (age[d] != 0);
  endtask

  task automatic new_req(input int d, input int p);
    pend[d][p] = 1;
    we[d][p] = $urandom_range(0, 1) != 0;
    addr[d][p] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 15))
                                             : AW'($urandom);
    wdata[d][p] = DW'($urandom);
  endtask

  initial begin
    bit rst;
    bit stress;
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 4096; a++) ref_mem[d][a] = seed(d, AW'(a));
      for (int p = 0; p < 2; p++) begin
        req[d][p] = 0; we[d][p] = 0; addr[d][p] = '0; wdata[d][p] = '0;
        pend[d][p] = 0;
      end
    end
    reset = 1'b1;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      if (c > 0) begin
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("d%0d.busy", d), 32'(busy[d]), 32'(e_busy[d]));
          chk($sformatf("d%0d.mem_en", d), 32'(m_en[d]), 32'(e_en[d]));
          if (e_en[d]) begin
            chk($sformatf("d%0d.mem_we", d), 32'(m_we[d]), 32'(e_we[d]));
            chk($sformatf("d%0d.mem_addr", d), 32'(m_addr[d]), 32'(e_addr[d]));
            if (e_we[d])
              chk($sformatf("d%0d.mem_wdata", d), 32'(m_wdata[d]),
                  32'(e_wdata[d]));
          end
          for (int p = 0; p < 2; p++) begin
            chk($sformatf("d%0d.p%0d.gnt", d, p), 32'(gnt[d][p]),
                32'(e_gnt[d][p]));
            chk($sformatf("d%0d.p%0d.done", d, p), 32'(done[d][p]),
                32'(e_done[d][p]));
            chk($sformatf("d%0d.p%0d.rdata", d, p), 32'(rdata[d][p]),
                32'(e_rdata[d][p]));
          end
        end
      end
      rst = (c < 3) || ($urandom_range(0, 149) == 0);
      stress = (c >= 2500 && c < 3700);
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++) begin
          if (c >= 3 && e_gnt[d][p]) begin
            pend[d][p] = 0;
            if (stress || $urandom_range(0, 1) != 0) new_req(d, p);
          end else if (!pend[d][p]) begin
            if (c >= 3 && (stress || $urandom_range(0, 2) == 0)) new_req(d, p);
          end else if (!stress && $urandom_range(0, 39) == 0) begin
            pend[d][p] = 0;
          end
          req[d][p] = pend[d][p];
        end
      end
      reset = rst;
      for (int d = 0; d < 2; d++) model_step(d);
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
